// File: rtl/pi_request_queue_pkg.sv
// Pi request queue: shared register map, firmware id and request metadata.
// Imported by the queue top and its FIFO.
package pi_request_queue_pkg;

  localparam logic [2:0] PI_REG_DATA_LO = 3'd0;
  localparam logic [2:0] PI_REG_DATA_HI = 3'd1;
  localparam logic [2:0] PI_REG_ADDR_LO = 3'd2;
  localparam logic [2:0] PI_REG_ADDR_HI = 3'd3;
  localparam logic [2:0] PI_REG_STATUS  = 3'd4;
  localparam logic [2:0] PI_REG_CONTROL = 3'd5;
  localparam logic [2:0] PI_REG_VERSION = 3'd6;

  localparam logic [7:0] FW_MAJOR     = 8'd2;
  localparam logic [5:0] FW_MINOR     = 6'd1;
  localparam logic       FW_TYPE_PS16 = 1'b1;
  localparam logic       FW_EXT_DATA  = 1'b1;

  typedef struct packed {
    logic [2:0]  fc;
    logic        is_read;
    logic [1:0]  size;
    logic [23:0] addr;
  } req_meta_t;

  localparam int META_W = $bits(req_meta_t);

endpackage

// File: rtl/pi_request_queue_fifo.sv
// Request FIFO: power-of-two ring buffer with level count.
// Head reads as zero while empty so the request bus idles at 0.
module req_fifo
  import pi_request_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = 62,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [LW-1:0]    level,
  output logic             full,
  output logic             empty,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (level == LVL_FULL);
  assign empty    = (level == '0);
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign overflow = push & full & ~do_pop;
  assign rdata    = empty ? '0 : mem[rd_ptr];

  always_ff @(negedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push & ~do_pop)
        level <= level + 1'b1;
      else if (do_pop & ~do_push)
        level <= level - 1'b1;
    end
  end

  always_ff @(negedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/pi_request_queue.sv
// Pi register front end queuing posted 68k bus requests
// and returning read data / completion status to the Pi.
module pi_request_queue
  import pi_request_queue_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic              SYSCLK,
  input  logic              SYS_RESET,
  input  logic [2:0]        PI_A,
  input  logic              PI_RD,
  input  logic              PI_WR,
  input  logic [15:0]       PI_DATA_IN,
  output logic [15:0]       PI_DATA_OUT,
  output logic              PI_DATA_OE,
  output logic              REQ_VALID,
  input  logic              REQ_READY,
  output logic [23:0]       REQ_ADDRESS,
  output logic [DATA_W-1:0] REQ_DATA,
  output logic [1:0]        REQ_SIZE,
  output logic [2:0]        REQ_FC,
  output logic              REQ_IS_READ,
  input  logic              RSP_VALID,
  input  logic [DATA_W-1:0] RSP_DATA,
  input  logic              RSP_ERROR,
  output logic              BUSY,
  output logic [14:0]       CONTROL
);

  localparam int LW = $clog2(DEPTH + 1);
  localparam int EW = META_W + DATA_W;
  localparam logic [2:0] RDV_CLR_REG =
    (DATA_W == 32) ? PI_REG_DATA_HI : PI_REG_DATA_LO;

  logic wr_s1, wr_s2, rd_s1, rd_s2;
  logic wr_ev, rd_ev;
  logic wr_dlo, wr_ahi, wr_alo, wr_ctl;
  logic flag_clr, rdv_clr, accept, rsp_done;

  logic [15:0]       stg_lo;
  logic [15:0]       addr_lo;
  logic [13:0]       addr_hi;
  logic [DATA_W-1:0] stg_data;
  logic [DATA_W-1:0] rdata;
  logic [15:0]       rdata_hi;
  logic              in_flight, inflight_rd;
  logic              err, ovf, rdv;

  logic [EW-1:0] push_entry, head;
  req_meta_t     push_meta, head_meta;
  logic [LW-1:0] level;
  logic [7:0]    lvl8;
  logic          full, empty, fifo_ovf;
  logic [15:0]   status;

  // Events fire on the edge where the synchronised strobe goes low
  assign wr_ev = wr_s2 & ~wr_s1;
  assign rd_ev = rd_s2 & ~rd_s1;

  assign wr_dlo   = wr_ev & (PI_A == PI_REG_DATA_LO);
  assign wr_alo   = wr_ev & (PI_A == PI_REG_ADDR_LO);
  assign wr_ahi   = wr_ev & (PI_A == PI_REG_ADDR_HI);
  assign wr_ctl   = wr_ev & (PI_A == PI_REG_CONTROL);
  assign flag_clr = wr_ctl & PI_DATA_IN[0];
  assign rdv_clr  = rd_ev & (PI_A == RDV_CLR_REG);

  if (DATA_W == 32) begin : g_hi
    logic [15:0] stg_hi;
    always_ff @(negedge SYSCLK) begin
      if (SYS_RESET)
        stg_hi <= '0;
      else if (wr_ev && PI_A == PI_REG_DATA_HI)
        stg_hi <= PI_DATA_IN;
    end
    assign stg_data = {stg_hi, stg_lo};
    assign rdata_hi = rdata[31:16];
  end else begin : g_lo
    assign stg_data = stg_lo;
    assign rdata_hi = '0;
  end

  // The pushed entry takes the ADDR_HI fields from the bus directly
  assign push_meta  = req_meta_t'({PI_DATA_IN[13:0], addr_lo});
  assign push_entry = {push_meta, stg_data};

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk      (SYSCLK),
    .rst      (SYS_RESET),
    .push     (wr_ahi),
    .pop      (accept),
    .wdata    (push_entry),
    .rdata    (head),
    .level    (level),
    .full     (full),
    .empty    (empty),
    .overflow (fifo_ovf)
  );

  assign head_meta   = req_meta_t'(head[EW-1:DATA_W]);
  assign REQ_VALID   = ~empty & ~in_flight;
  assign REQ_ADDRESS = head_meta.addr;
  assign REQ_SIZE    = head_meta.size;
  assign REQ_FC      = head_meta.fc;
  assign REQ_IS_READ = head_meta.is_read;
  assign REQ_DATA    = head[DATA_W-1:0];
  assign accept      = REQ_VALID & REQ_READY;
  assign rsp_done    = RSP_VALID & in_flight;
  assign BUSY        = ~empty | in_flight;
  assign PI_DATA_OE  = ~PI_RD & PI_WR;

  always_ff @(negedge SYSCLK) begin
    if (SYS_RESET) begin
      wr_s1       <= 1'b1;
      wr_s2       <= 1'b1;
      rd_s1       <= 1'b1;
      rd_s2       <= 1'b1;
      stg_lo      <= '0;
      addr_lo     <= '0;
      addr_hi     <= '0;
      CONTROL     <= '0;
      in_flight   <= 1'b0;
      inflight_rd <= 1'b0;
      err         <= 1'b0;
      ovf         <= 1'b0;
      rdv         <= 1'b0;
      rdata       <= '0;
    end else begin
      wr_s1 <= PI_WR;
      wr_s2 <= wr_s1;
      rd_s1 <= PI_RD;
      rd_s2 <= rd_s1;
      if (wr_dlo) stg_lo  <= PI_DATA_IN;
      if (wr_alo) addr_lo <= PI_DATA_IN;
      if (wr_ahi) addr_hi <= PI_DATA_IN[13:0];
      if (wr_ctl)
        CONTROL <= PI_DATA_IN[15] ? (CONTROL | PI_DATA_IN[14:0])
                                  : (CONTROL & ~PI_DATA_IN[14:0]);
      ovf <= (ovf & ~flag_clr) | fifo_ovf;
      err <= (err & ~flag_clr) | (rsp_done & RSP_ERROR);
      if (accept) begin
        in_flight   <= 1'b1;
        inflight_rd <= head_meta.is_read;
      end else if (rsp_done) begin
        in_flight <= 1'b0;
      end
      // A completing read beats a same-cycle clearing read event
      if (rsp_done && inflight_rd) begin
        rdata <= RSP_DATA;
        rdv   <= 1'b1;
      end else if (rdv_clr) begin
        rdv <= 1'b0;
      end
    end
  end

  assign lvl8   = 8'(level);
  assign status = {lvl8, 1'b0, in_flight, BUSY, err,
                   rdv, ovf, full, empty};

  always_comb begin
    PI_DATA_OUT = '0;
    case (PI_A)
      PI_REG_DATA_LO: PI_DATA_OUT = rdata[15:0];
      PI_REG_DATA_HI: PI_DATA_OUT = rdata_hi;
      PI_REG_ADDR_LO: PI_DATA_OUT = addr_lo;
      PI_REG_ADDR_HI: PI_DATA_OUT = {2'b00, addr_hi};
      PI_REG_STATUS:  PI_DATA_OUT = status;
      PI_REG_VERSION: PI_DATA_OUT = {FW_MAJOR, FW_MINOR,
                                     FW_TYPE_PS16, FW_EXT_DATA};
      default:        PI_DATA_OUT = '0;
    endcase
  end

endmodule

// File: tb/tb_pi_request_queue.sv
// Directed bench for pi_request_queue: a 32-bit/DEPTH=8 instance
// and a 16-bit/DEPTH=4 instance sharing the Pi bus.
module tb_pi_request_queue;

  localparam logic [2:0] A_DLO  = 3'd0;
  localparam logic [2:0] A_DHI  = 3'd1;
  localparam logic [2:0] A_ALO  = 3'd2;
  localparam logic [2:0] A_AHI  = 3'd3;
  localparam logic [2:0] A_STAT = 3'd4;
  localparam logic [2:0] A_CTRL = 3'd5;
  localparam logic [2:0] A_VER  = 3'd6;

  logic        SYSCLK = 1'b1;
  logic        SYS_RESET = 1'b1;
  logic [2:0]  PI_A = '0;
  logic        PI_RD = 1'b1;
  logic        PI_WR = 1'b1;
  logic [15:0] PI_DATA_IN = '0;

  logic        REQ_READY = 1'b0;
  logic        RSP_VALID = 1'b0;
  logic [31:0] RSP_DATA = '0;
  logic        RSP_ERROR = 1'b0;
  logic [15:0] PI_DATA_OUT;
  logic        PI_DATA_OE, REQ_VALID, REQ_IS_READ, BUSY;
  logic [23:0] REQ_ADDRESS;
  logic [31:0] REQ_DATA;
  logic [1:0]  REQ_SIZE;
  logic [2:0]  REQ_FC;
  logic [14:0] CONTROL;

  logic        ready2 = 1'b0;
  logic        rspv2 = 1'b0;
  logic [15:0] rspd2 = '0;
  logic        rspe2 = 1'b0;
  logic [15:0] dout2;
  logic        oe2, valid2, isrd2, busy2;
  logic [23:0] addr2;
  logic [15:0] data2;
  logic [1:0]  size2;
  logic [2:0]  fc2;
  logic [14:0] ctrl2;

  int passed = 0;
  int total  = 0;

  always #5 SYSCLK = ~SYSCLK;

  pi_request_queue #(.DEPTH(8), .DATA_W(32)) dut (
    .SYSCLK(SYSCLK), .SYS_RESET(SYS_RESET), .PI_A(PI_A),
    .PI_RD(PI_RD), .PI_WR(PI_WR), .PI_DATA_IN(PI_DATA_IN),
    .PI_DATA_OUT(PI_DATA_OUT), .PI_DATA_OE(PI_DATA_OE),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
    .REQ_ADDRESS(REQ_ADDRESS), .REQ_DATA(REQ_DATA),
    .REQ_SIZE(REQ_SIZE), .REQ_FC(REQ_FC), .REQ_IS_READ(REQ_IS_READ),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .RSP_ERROR(RSP_ERROR),
    .BUSY(BUSY), .CONTROL(CONTROL)
  );

  pi_request_queue #(.DEPTH(4), .DATA_W(16)) dut16 (
    .SYSCLK(SYSCLK), .SYS_RESET(SYS_RESET), .PI_A(PI_A),
    .PI_RD(PI_RD), .PI_WR(PI_WR), .PI_DATA_IN(PI_DATA_IN),
    .PI_DATA_OUT(dout2), .PI_DATA_OE(oe2),
    .REQ_VALID(valid2), .REQ_READY(ready2),
    .REQ_ADDRESS(addr2), .REQ_DATA(data2),
    .REQ_SIZE(size2), .REQ_FC(fc2), .REQ_IS_READ(isrd2),
    .RSP_VALID(rspv2), .RSP_DATA(rspd2), .RSP_ERROR(rspe2),
    .BUSY(busy2), .CONTROL(ctrl2)
  );

  typedef struct {
    logic [2:0]  a;
    logic [15:0] d;
    logic [2:0]  ra;
    logic [15:0] exp_rd;
    logic [14:0] exp_ctrl;
  } vec_t;

  vec_t vecs[8];
  int   drain_exp[8];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge SYSCLK);
  endtask

  task automatic chk_reg(input string name, input logic [2:0] a,
                         input logic [15:0] exp);
    PI_A = a;
    #1;
    check(name, {16'h0, PI_DATA_OUT}, {16'h0, exp});
  endtask

  task automatic chk_reg16(input string name, input logic [2:0] a,
                           input logic [15:0] exp);
    PI_A = a;
    #1;
    check(name, {16'h0, dout2}, {16'h0, exp});
  endtask

  task automatic pi_write(input logic [2:0] a, input logic [15:0] d);
    @(posedge SYSCLK);
    PI_A = a;
    PI_DATA_IN = d;
    PI_WR = 1'b0;
    cyc(3);
    PI_WR = 1'b1;
    cyc(3);
  endtask

  task automatic pi_rd_event(input logic [2:0] a);
    @(posedge SYSCLK);
    PI_A = a;
    PI_RD = 1'b0;
    cyc(3);
    PI_RD = 1'b1;
    cyc(3);
  endtask

  task automatic pulse_ready();
    @(posedge SYSCLK);
    REQ_READY = 1'b1;
    @(posedge SYSCLK);
    REQ_READY = 1'b0;
    #1;
  endtask

  task automatic rsp(input logic [31:0] d, input logic e);
    @(posedge SYSCLK);
    RSP_VALID = 1'b1;
    RSP_DATA = d;
    RSP_ERROR = e;
    @(posedge SYSCLK);
    RSP_VALID = 1'b0;
    RSP_ERROR = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(posedge SYSCLK);
    SYS_RESET = 1'b1;
    @(posedge SYSCLK);
    SYS_RESET = 1'b0;
    #1;
  endtask

  initial begin
    vecs[0] = '{A_ALO,  16'h2000, A_ALO,  16'h2000, 15'h0000};
    vecs[1] = '{A_CTRL, 16'h8005, A_STAT, 16'h0001, 15'h0005};
    vecs[2] = '{A_CTRL, 16'h8030, A_STAT, 16'h0001, 15'h0035};
    vecs[3] = '{A_CTRL, 16'h0004, A_VER,  16'h0207, 15'h0031};
    vecs[4] = '{A_DHI,  16'hBEEF, A_DHI,  16'h0000, 15'h0031};
    vecs[5] = '{A_AHI,  16'h0401, A_AHI,  16'h0401, 15'h0031};
    vecs[6] = '{3'd7,   16'hFFFF, A_ALO,  16'h2000, 15'h0031};
    vecs[7] = '{A_CTRL, 16'h0001, A_STAT, 16'h0120, 15'h0030};
    drain_exp = '{1, 2, 3, 4, 5, 6, 7, 9};

    cyc(3);
    SYS_RESET = 1'b0;
    #1;
    // reset state
    chk_reg("rst status", A_STAT, 16'h0001);
    check("rst valid", REQ_VALID, 0);
    check("rst busy", BUSY, 0);
    check("rst control", CONTROL, 0);
    check("rst addr", REQ_ADDRESS, 0);
    check("rst oe", PI_DATA_OE, 0);
    PI_RD = 1'b0;
    #1;
    check("oe on read", PI_DATA_OE, 1);
    PI_RD = 1'b1;

    // register table
    for (int i = 0; i < 8; i++) begin
      pi_write(vecs[i].a, vecs[i].d);
      chk_reg($sformatf("vec%0d rd", i), vecs[i].ra, vecs[i].exp_rd);
      check($sformatf("vec%0d ctrl", i), CONTROL, vecs[i].exp_ctrl);
    end

    // single read request
    check("req valid", REQ_VALID, 1);
    check("req addr", REQ_ADDRESS, 24'h012000);
    check("req is_read", REQ_IS_READ, 1);
    check("req size", REQ_SIZE, 0);
    check("req fc", REQ_FC, 0);
    check("req data", REQ_DATA, 32'hBEEF0000);
    pulse_ready();
    check("accepted valid", REQ_VALID, 0);
    chk_reg("inflight status", A_STAT, 16'h0061);
    rsp(32'hCAFEBABE, 1'b0);
    chk_reg("rdv status", A_STAT, 16'h0009);
    chk_reg("rdata hi", A_DHI, 16'hCAFE);
    chk_reg("rdata lo", A_DLO, 16'hBABE);
    pi_rd_event(A_DHI);
    chk_reg("rdv cleared", A_STAT, 16'h0001);

    // rsp and clearing read event on the same edge
    pi_write(A_AHI, 16'h0401);
    pulse_ready();
    rsp(32'hCAFEBABE, 1'b0);
    pi_write(A_AHI, 16'h0401);
    pulse_ready();
    @(posedge SYSCLK);
    PI_A = A_DHI;
    PI_RD = 1'b0;
    @(posedge SYSCLK);
    RSP_VALID = 1'b1;
    RSP_DATA = 32'h12345678;
    @(posedge SYSCLK);
    RSP_VALID = 1'b0;
    cyc(1);
    PI_RD = 1'b1;
    cyc(3);
    chk_reg("set wins rdv", A_STAT, 16'h0009);
    chk_reg("set wins data", A_DLO, 16'h5678);
    pi_rd_event(A_DHI);
    chk_reg("rdv clr 2", A_STAT, 16'h0001);

    // burst to full, overflow, clear
    do_reset();
    for (int i = 0; i < 8; i++) pi_write(A_AHI, 16'(i));
    chk_reg("full status", A_STAT, 16'h0822);
    pi_write(A_AHI, 16'h0008);
    chk_reg("overflow status", A_STAT, 16'h0826);
    pi_write(A_CTRL, 16'h8001);
    chk_reg("ovf cleared", A_STAT, 16'h0822);
    check("ctrl 0001", CONTROL, 15'h0001);

    // push and pop on the same edge while full
    @(posedge SYSCLK);
    PI_A = A_AHI;
    PI_DATA_IN = 16'h0009;
    PI_WR = 1'b0;
    @(posedge SYSCLK);
    REQ_READY = 1'b1;
    @(posedge SYSCLK);
    REQ_READY = 1'b0;
    cyc(1);
    PI_WR = 1'b1;
    cyc(3);
    chk_reg("push+pop full", A_STAT, 16'h0862);

    // drain across pointer wrap; first completion errors
    for (int k = 0; k < 8; k++) begin
      rsp(32'h0, k == 0);
      check($sformatf("drain%0d valid", k), REQ_VALID, 1);
      check($sformatf("drain%0d addr", k), REQ_ADDRESS,
            32'(drain_exp[k]) << 16);
      pulse_ready();
    end
    rsp(32'h0, 1'b0);
    chk_reg("err status", A_STAT, 16'h0011);
    rsp(32'hFFFFFFFF, 1'b1);
    chk_reg("stray rsp status", A_STAT, 16'h0011);
    chk_reg("stray rsp data", A_DLO, 16'h0000);
    pi_write(A_CTRL, 16'h0001);
    chk_reg("err cleared", A_STAT, 16'h0001);
    check("ctrl cleared", CONTROL, 0);

    // reset with a request in flight
    pi_write(A_CTRL, 16'h8003);
    for (int i = 1; i <= 4; i++) pi_write(A_AHI, 16'h0400 | 16'(i));
    pulse_ready();
    chk_reg("pre-reset status", A_STAT, 16'h0360);
    do_reset();
    chk_reg("post-reset status", A_STAT, 16'h0001);
    check("post-reset valid", REQ_VALID, 0);
    check("post-reset busy", BUSY, 0);
    check("post-reset ctrl", CONTROL, 0);
    check("post-reset addr", REQ_ADDRESS, 0);
    check("post-reset data", REQ_DATA, 0);
    check("post-reset is_read", REQ_IS_READ, 0);
    rsp(32'hAAAA5555, 1'b1);
    chk_reg("ignored rsp", A_STAT, 16'h0001);
    chk_reg("ignored rsp data", A_DHI, 16'h0000);

    // 16-bit instance
    do_reset();
    pi_write(A_DLO, 16'h1111);
    pi_write(A_DHI, 16'h2222);
    pi_write(A_AHI, 16'h0401);
    check("w16 req data", data2, 16'h1111);
    check("w32 req data", REQ_DATA, 32'h22221111);
    check("w16 is_read", isrd2, 1);
    @(posedge SYSCLK);
    ready2 = 1'b1;
    @(posedge SYSCLK);
    ready2 = 1'b0;
    @(posedge SYSCLK);
    rspv2 = 1'b1;
    rspd2 = 16'hBEEF;
    @(posedge SYSCLK);
    rspv2 = 1'b0;
    #1;
    chk_reg16("w16 rdv", A_STAT, 16'h0009);
    chk_reg16("w16 data hi", A_DHI, 16'h0000);
    chk_reg16("w16 data lo", A_DLO, 16'hBEEF);
    pi_rd_event(A_DHI);
    chk_reg16("w16 hi read keeps rdv", A_STAT, 16'h0009);
    pi_rd_event(A_DLO);
    chk_reg16("w16 lo read clears rdv", A_STAT, 16'h0001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
